// File: rtl/leg_exec_unit.sv
// leg_exec_unit: LEG CPU execute stage with fetch redirect/flush and handshaked I/O ports (optional shifts via LEG_EXEC_SHIFT_EN)
module leg_exec_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dir,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic [7:0] address,
  output logic       skip,
  output logic [7:0] skip_data,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
`ifdef LEG_EXEC_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [7:0] regs [6];
  logic [7:0] pc_q, cnt, a, b, res, target;
  logic [2:0] op, dst;
  logic cond, nop, run, rd_a7, rd_b7, wr7, stall, taken, exec, redirect;
  always_comb begin
    op = dir[2:0];
    dst = address[2:0];
    cond = dir[5];
    run = state == RUN;
    nop = dir[4:3] != 2'b00 || (!cond && op[2:1] == 2'b11 && !SHIFT_EN);
    a = dir[7] ? data_a : data_a[2:0] == 3'd7 ? in_data : data_a[2:0] == 3'd6 ? pc_q : regs[data_a[2:0]];
    b = dir[6] ? data_b : data_b[2:0] == 3'd7 ? in_data : data_b[2:0] == 3'd6 ? pc_q : regs[data_b[2:0]];
    rd_a7 = !nop && !dir[7] && data_a[2:0] == 3'd7;
    rd_b7 = !nop && !dir[6] && data_b[2:0] == 3'd7 && (cond || op != 3'd4);
    wr7 = !nop && !cond && dst == 3'd7;
    stall = run && (((rd_a7 || rd_b7) && !in_valid) || (wr7 && out_valid && !out_ready));
    exec = run && !stall && !nop;
    res = 8'h00;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = ~a;
      3'd5: res = a ^ b;
      3'd6: res = a << b[2:0];
      default: res = a >> b[2:0];
    endcase
    taken = 1'b0;
    case (op)
      3'd0: taken = a == b;
      3'd1: taken = a != b;
      3'd2: taken = a < b;
      3'd3: taken = a <= b;
      3'd4: taken = a > b;
      3'd5: taken = a >= b;
      3'd6: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    redirect = stall || (exec && (cond ? taken : dst == 3'd6));
    target = stall ? pc_q : cond ? address : res;
    in_ready = !rst && exec && (rd_a7 || rd_b7);
    state_n = state;
    if (run && redirect && FLUSH_CYCLES > 0) state_n = FLUSH;
    if (!run && cnt <= 8'd1) state_n = RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      regs <= '{default: 8'h00};
      pc_q <= 8'h00;
      cnt <= 8'h00;
      skip <= 1'b0;
      skip_data <= 8'h00;
      out_data <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      skip <= redirect;
      if (redirect) begin
        skip_data <= target;
        pc_q <= target;
        cnt <= 8'(FLUSH_CYCLES);
      end else if (run) pc_q <= pc_q + 8'd1;
      else cnt <= cnt - 8'd1;
      if (exec && !cond && dst < 3'd6) regs[dst] <= res;
      // a write in the same cycle as a handshake reloads the port instead of clearing it
      if (exec && wr7) begin
        out_data <= res;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule
